rect_param_scheduler: RTL
=========================

Name: rect_param_scheduler

Overview:
- Sequences parameter refresh for the rectangle-pattern pixel datapath.
- On each tempo pulse, fetches random words one at a time from the LFSR source over a req/valid handshake into a shadow bank.
- Copies the shadow bank to the active bank atomically at the next frame boundary, so shapes never tear mid-frame.
- Sits between the LFSR/tempo blocks and the colour-out logic, which reads only the active bank.

Parameters:
- NUM_SLOTS, 7, number of rectangle slots.
- MIN_HALF, 4, minimum half-width/half-height after clamping.
- RESET_HALF, 32, half-size of every slot after reset.
- RESET_COLOR, 12'h888, colour of every slot after reset.

Ports:
- clk_in  in  1  pixel clock.
- reset  in  1  asynchronous, active-high reset.
- half_sec_pulse  in  1  one-cycle tempo strobe; requests a refresh.
- frame_end  in  1  one-cycle strobe at the first blanking line of each frame.
- freeze  in  1  while high, new half_sec_pulse strobes are ignored.
- rnd_in  in  13  random word from the LFSR source.
- rnd_valid  in  1  rnd_in is valid this cycle.
- rnd_req  out  1  request for a random word.
- busy  out  1  high in FETCH or READY.
- commit  out  1  one-cycle pulse when the active bank updates.
- h_half  out  9*NUM_SLOTS  active half-widths; slot k at bits [9k+8:9k].
- v_half  out  9*NUM_SLOTS  active half-heights; same packing as h_half.
- color  out  12*NUM_SLOTS  active {r,g,b} 4 bits each; slot k at bits [12k+11:12k].

Behaviour:
- Reset (asynchronous):
  - state=IDLE, pending=0, slot=0, field=0.
  - rnd_req=0, busy=0, commit=0.
  - Every active and shadow slot: h_half=v_half=RESET_HALF, color=RESET_COLOR.
- Reset mid-FETCH or mid-READY discards the shadow bank; the active bank returns to reset values.
- States:
  - IDLE: on half_sec_pulse & !freeze, go to FETCH with slot=0, field=0.
  - FETCH:
    - rnd_req=1 (registered; high from the first FETCH cycle).
    - A capture occurs on a cycle with rnd_req & rnd_valid.
    - Capture order per slot: field 0 h_half, field 1 v_half, field 2 color.
    - field wraps 2->0 and increments slot.
    - After the capture for slot NUM_SLOTS-1, field 2: go to READY and drop rnd_req on the next cycle.
    - rnd_valid while rnd_req=0 is ignored.
    - Total captures = 3*NUM_SLOTS. With rnd_valid held high, FETCH lasts exactly 3*NUM_SLOTS cycles.
  - READY: on frame_end, copy the whole shadow bank to the active bank in one cycle, pulse commit for that one cycle, then:
    - go to FETCH (slot=0, field=0) if pending, clearing pending;
    - otherwise go to IDLE.
- Field rules:
  - h_half = max(rnd_in[8:0], MIN_HALF).
  - v_half = max(rnd_in[12:4], MIN_HALF).
  - color = rnd_in[11:0].
  - Compares are unsigned.
- Pending:
  - half_sec_pulse & !freeze while in FETCH or READY sets pending.
  - Multiple pulses collapse into one.
  - A pulse arriving on the commit cycle also sets pending.
- frame_end handling:
  - frame_end outside READY is ignored.
  - frame_end on the same cycle as the final capture is not honoured; commit waits for the next frame_end.
- The active bank changes only on the commit cycle.
- freeze does not abort an in-progress FETCH or READY.

Decomposition:
- Shared package:
  - HALF_W=9, COLOR_W=12, RND_W=13.
  - State encoding: IDLE, FETCH, READY.
  - Field index constants: F_H=0, F_V=1, F_C=2.
- One sub-module, rect_slot_bank:
  - Holds the shadow and active arrays.
  - Performs the field write with clamp.
  - Performs the bulk commit copy.
  - The FSM stays in the top.

Test Plan:
- Reset, then idle 100 cycles -> all slots h_half=v_half=32, color=12'h888; rnd_req=0; commit never pulses.
- half_sec_pulse; rnd_valid=1 constantly; rnd_in counts 0,1,2,...:
  - rnd_req high exactly 21 cycles.
  - Active bank unchanged until frame_end.
  - Commit on that frame_end gives slot0 h_half=4 (0 clamped), v_half=4, color=12'h002; slot1 h_half=4, v_half=4, color=12'h005.
- rnd_valid toggling 1-in-3 cycles -> 21 captures in correct order; no capture while rnd_req=0; busy stays high through READY until commit.
- Two half_sec_pulses during FETCH plus one on the commit cycle -> exactly one extra FETCH follows the commit, then IDLE after the second commit.
- freeze=1 with a pulse in IDLE -> no rnd_req. Pulse, then freeze=1 in FETCH -> fetch and commit still complete.
- Assert reset mid-FETCH at capture 10 -> outputs return to reset values immediately; no commit pulse; the next pulse restarts at slot 0, field 0.

Source files
------------

// File: rtl/rect_param_scheduler_pkg.sv
// Shared widths, FSM state encoding and field indices for the rectangle
// parameter scheduler.
package rect_param_scheduler_pkg;

  localparam int HALF_W  = 9;
  localparam int COLOR_W = 12;
  localparam int RND_W   = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    READY = 2'd2
  } state_e;

  localparam logic [1:0] F_H = 2'd0;
  localparam logic [1:0] F_V = 2'd1;
  localparam logic [1:0] F_C = 2'd2;

endpackage

// File: rtl/rect_slot_bank.sv
// Shadow and active rectangle parameter banks: clamped field writes into the
// shadow bank and a single-cycle bulk copy from shadow to active.
module rect_slot_bank
  import rect_param_scheduler_pkg::*;
#(
  parameter int                 NUM_SLOTS   = 7,
  parameter int                 MIN_HALF    = 4,
  parameter int                 RESET_HALF  = 32,
  parameter logic [COLOR_W-1:0] RESET_COLOR = 12'h888,
  parameter int                 SLOT_W      = 3
) (
  input  logic                           clk_in,
  input  logic                           reset,
  input  logic                           wr_en,
  input  logic [SLOT_W-1:0]              wr_slot,
  input  logic [1:0]                     wr_field,
  input  logic [RND_W-1:0]               wr_data,
  input  logic                           commit_en,
  output logic [HALF_W*NUM_SLOTS-1:0]    h_half,
  output logic [HALF_W*NUM_SLOTS-1:0]    v_half,
  output logic [COLOR_W*NUM_SLOTS-1:0]   color
);

  function automatic logic [HALF_W-1:0] clamp_half(input logic [HALF_W-1:0] raw);
    return (raw < HALF_W'(MIN_HALF)) ? HALF_W'(MIN_HALF) : raw;
  endfunction

  logic [HALF_W-1:0]  sh_h_q  [NUM_SLOTS];
  logic [HALF_W-1:0]  sh_h_d  [NUM_SLOTS];
  logic [HALF_W-1:0]  sh_v_q  [NUM_SLOTS];
  logic [HALF_W-1:0]  sh_v_d  [NUM_SLOTS];
  logic [COLOR_W-1:0] sh_c_q  [NUM_SLOTS];
  logic [COLOR_W-1:0] sh_c_d  [NUM_SLOTS];
  logic [HALF_W-1:0]  act_h_q [NUM_SLOTS];
  logic [HALF_W-1:0]  act_h_d [NUM_SLOTS];
  logic [HALF_W-1:0]  act_v_q [NUM_SLOTS];
  logic [HALF_W-1:0]  act_v_d [NUM_SLOTS];
  logic [COLOR_W-1:0] act_c_q [NUM_SLOTS];
  logic [COLOR_W-1:0] act_c_d [NUM_SLOTS];

  always_comb begin
    sh_h_d  = sh_h_q;
    sh_v_d  = sh_v_q;
    sh_c_d  = sh_c_q;
    act_h_d = act_h_q;
    act_v_d = act_v_q;
    act_c_d = act_c_q;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (wr_en && (wr_slot == SLOT_W'(k))) begin
        case (wr_field)
          F_H:     sh_h_d[k] = clamp_half(wr_data[HALF_W-1:0]);
          F_V:     sh_v_d[k] = clamp_half(wr_data[RND_W-1 -: HALF_W]);
          F_C:     sh_c_d[k] = wr_data[COLOR_W-1:0];
          default: ;
        endcase
      end
    end
    // Copy reads the shadow registers, never a same-cycle write.
    if (commit_en) begin
      act_h_d = sh_h_q;
      act_v_d = sh_v_q;
      act_c_d = sh_c_q;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_SLOTS; k++) begin
        sh_h_q[k]  <= HALF_W'(RESET_HALF);
        sh_v_q[k]  <= HALF_W'(RESET_HALF);
        sh_c_q[k]  <= RESET_COLOR;
        act_h_q[k] <= HALF_W'(RESET_HALF);
        act_v_q[k] <= HALF_W'(RESET_HALF);
        act_c_q[k] <= RESET_COLOR;
      end
    end else begin
      sh_h_q  <= sh_h_d;
      sh_v_q  <= sh_v_d;
      sh_c_q  <= sh_c_d;
      act_h_q <= act_h_d;
      act_v_q <= act_v_d;
      act_c_q <= act_c_d;
    end
  end

  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_pack
    assign h_half[k*HALF_W +: HALF_W]   = act_h_q[k];
    assign v_half[k*HALF_W +: HALF_W]   = act_v_q[k];
    assign color[k*COLOR_W +: COLOR_W]  = act_c_q[k];
  end

endmodule

// File: rtl/rect_param_scheduler.sv
// Refresh sequencer: fetches 3 random words per slot into the shadow bank on a
// tempo pulse, then commits them to the active bank at the next frame boundary.
module rect_param_scheduler
  import rect_param_scheduler_pkg::*;
#(
  parameter int                 NUM_SLOTS   = 7,
  parameter int                 MIN_HALF    = 4,
  parameter int                 RESET_HALF  = 32,
  parameter logic [COLOR_W-1:0] RESET_COLOR = 12'h888
) (
  input  logic                           clk_in,
  input  logic                           reset,
  input  logic                           half_sec_pulse,
  input  logic                           frame_end,
  input  logic                           freeze,
  input  logic [RND_W-1:0]               rnd_in,
  input  logic                           rnd_valid,
  output logic                           rnd_req,
  output logic                           busy,
  output logic                           commit,
  output logic [HALF_W*NUM_SLOTS-1:0]    h_half,
  output logic [HALF_W*NUM_SLOTS-1:0]    v_half,
  output logic [COLOR_W*NUM_SLOTS-1:0]   color
);

  localparam int               SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

  state_e            state_q, state_d;
  logic              pending_q, pending_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [1:0]        field_q, field_d;
  logic              rnd_req_q, rnd_req_d;
  logic              pulse_ok, capture, last_capture, commit_en;

  always_comb begin
    pulse_ok     = half_sec_pulse & ~freeze;
    capture      = (state_q == FETCH) & rnd_req_q & rnd_valid;
    last_capture = capture & (slot_q == LAST_SLOT) & (field_q == F_C);
    commit_en    = (state_q == READY) & frame_end;
    state_d      = state_q;
    pending_d    = pending_q;
    slot_d       = slot_q;
    field_d      = field_q;
    case (state_q)
      IDLE: begin
        if (pulse_ok) begin
          state_d = FETCH;
          slot_d  = '0;
          field_d = F_H;
        end
      end
      FETCH: begin
        if (pulse_ok) pending_d = 1'b1;
        if (capture) begin
          if (field_q == F_C) begin
            field_d = F_H;
            slot_d  = last_capture ? '0 : slot_q + SLOT_W'(1);
          end else begin
            field_d = field_q + 2'd1;
          end
          if (last_capture) state_d = READY;
        end
      end
      READY: begin
        if (pulse_ok) pending_d = 1'b1;
        // A pulse on the commit cycle merges with any pending request.
        if (commit_en) begin
          if (pending_q | pulse_ok) begin
            state_d   = FETCH;
            slot_d    = '0;
            field_d   = F_H;
            pending_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    rnd_req_d = (state_d == FETCH);
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      slot_q    <= '0;
      field_q   <= F_H;
      rnd_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      slot_q    <= slot_d;
      field_q   <= field_d;
      rnd_req_q <= rnd_req_d;
    end
  end

  assign rnd_req = rnd_req_q;
  assign busy    = (state_q != IDLE);
  assign commit  = commit_en;

  rect_slot_bank #(
    .NUM_SLOTS   (NUM_SLOTS),
    .MIN_HALF    (MIN_HALF),
    .RESET_HALF  (RESET_HALF),
    .RESET_COLOR (RESET_COLOR),
    .SLOT_W      (SLOT_W)
  ) u_bank (
    .clk_in    (clk_in),
    .reset     (reset),
    .wr_en     (capture),
    .wr_slot   (slot_q),
    .wr_field  (field_q),
    .wr_data   (rnd_in),
    .commit_en (commit_en),
    .h_half    (h_half),
    .v_half    (v_half),
    .color     (color)
  );

endmodule
